// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring shift-subtract divider, unsigned or two's complement signed.
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [N-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic nq_q, nq_d, nr_q, nr_d, dz_q, dz_d, done_q, done_d, div_zero_q, div_zero_d;
  logic [N:0] sh;
  logic [N-1:0] diff, a_mag, b_mag;
  logic carry;
  always_comb begin
    a_mag = (sgn && dividend[N-1]) ? -dividend : dividend;
    b_mag = (sgn && divisor[N-1]) ? -divisor : divisor;
    sh = {rem_q, quo_q[N-1]};
    carry = sh >= {1'b0, dvs_q};
    // a kept difference is always below the divisor, so the low N bits are exact
    diff = sh[N-1:0] - dvs_q;
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    nq_d = nq_q;
    nr_d = nr_q;
    dz_d = dz_q;
    quotient_d = quotient_q;
    remainder_d = remainder_q;
    div_zero_d = div_zero_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        dz_d = divisor == '0;
        quo_d = dz_d ? '1 : a_mag;
        rem_d = dz_d ? dividend : '0;
        dvs_d = b_mag;
        nq_d = !dz_d && sgn && (dividend[N-1] ^ divisor[N-1]);
        nr_d = !dz_d && sgn && dividend[N-1];
        cnt_d = CW'(N);
        state_d = dz_d ? FIX : CALC;
      end
      CALC: begin
        rem_d = carry ? diff : sh[N-1:0];
        quo_d = {quo_q[N-2:0], carry};
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? FIX : CALC;
      end
      FIX: begin
        quotient_d = nq_q ? -quo_q : quo_q;
        remainder_d = nr_q ? -rem_q : rem_q;
        div_zero_d = dz_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
      dz_q <= 1'b0;
      quotient_q <= '0;
      remainder_q <= '0;
      div_zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      nq_q <= nq_d;
      nr_q <= nr_d;
      dz_q <= dz_d;
      quotient_q <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q <= div_zero_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign quotient = quotient_q;
  assign remainder = remainder_q;
  assign div_zero = div_zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed-vector bench for seq_divider at N=8.
module tb_seq_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sgn = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_zero;
  logic [7:0] quotient, remainder;
  int checks = 0, errors = 0;
  int lat, cnt;
  bit bok;
  seq_divider #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input logic s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    sgn = s;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    sgn = 1'($urandom);
    dividend = 8'($urandom);
    divisor = 8'($urandom);
  endtask
  task automatic wait_done(output int l, output bit ok);
    l = -1;
    ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        l = k;
        break;
      end
      if (!busy) ok = 1'b0;
    end
  endtask
  task automatic run(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic edz, input int elat);
    int l;
    bit ok;
    pulse(s, a, b);
    chk({tag, " busy_after_accept"}, 32'(busy), 1);
    wait_done(l, ok);
    chk({tag, " latency"}, 32'(l), 32'(elat));
    chk({tag, " busy_held"}, 32'(ok), 1);
    chk({tag, " busy_at_done"}, 32'(busy), 0);
    chk({tag, " q"}, 32'(quotient), 32'(eq));
    chk({tag, " r"}, 32'(remainder), 32'(er));
    chk({tag, " dz"}, 32'(div_zero), 32'(edz));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset q", 32'(quotient), 0);
    chk("reset r", 32'(remainder), 0);
    chk("reset dz", 32'(div_zero), 0);
    run("u100/7", 1'b0, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 9);
    run("s-7/2", 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9);
    run("s7/-2", 1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);
    run("s-100/-7", 1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 9);
    run("u2A/0", 1'b0, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 1);
    run("s2A/0", 1'b1, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 1);
    run("u2A/1", 1'b0, 8'h2A, 8'h01, 8'h2A, 8'h00, 1'b0, 9);
    run("s80/FF", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    run("u80/FF", 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9);
    // start re-pulsed while busy must be ignored
    pulse(1'b0, 8'd200, 8'd3);
    repeat (3) @(negedge clk);
    start = 1'b1;
    dividend = 8'd9;
    divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bok);
    chk("busy_start latency", 32'(lat + 4), 9);
    chk("busy_start q", 32'(quotient), 66);
    chk("busy_start r", 32'(remainder), 2);
    // start on the done cycle is accepted; old results stay until the new done
    start = 1'b1;
    sgn = 1'b0;
    dividend = 8'd50;
    divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    chk("done_start busy", 32'(busy), 1);
    chk("done_start old q", 32'(quotient), 66);
    wait_done(lat, bok);
    chk("done_start latency", 32'(lat), 9);
    chk("done_start q", 32'(quotient), 7);
    chk("done_start r", 32'(remainder), 1);
    // reset in flight aborts without a done
    pulse(1'b0, 8'd255, 8'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort q", 32'(quotient), 0);
    chk("abort r", 32'(remainder), 0);
    chk("abort dz", 32'(div_zero), 0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort no_done", 32'(cnt), 0);
    run("u50/5", 1'b0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle N-bit integer divider; supports unsigned and signed (two's complement) operands.
- Runs a restoring shift-subtract loop, one quotient bit per cycle.
- Each step is a trial subtract; the adder carry-out (1 = no borrow) selects restore or keep.
- Sits beside the combinational add/sub ALU as its iterative counterpart; consumes the same carry-out semantics.

Parameters:
N, 8, operand/result width in bits (N >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a division; accepted only when busy=0
sgn  input  1  1 = signed operands, 0 = unsigned; sampled with start
dividend  input  N  numerator, sampled with start
divisor  input  N  denominator, sampled with start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse, results valid
quotient  output  N  result quotient, held until next accepted start
remainder  output  N  result remainder, held until next accepted start
div_zero  output  1  divisor was zero for the last result, held with results

Behaviour:
- Reset: state IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; iteration counter=0. Reset wins over start and aborts any operation in flight; no done is produced for an aborted operation.
- States: IDLE, CALC, FIX.
- Edge E0 (start=1, busy=0): latch operands and sgn.
  - Divisor==0: go directly to FIX with the div-zero result.
  - Otherwise: load magnitudes (absolute value if sgn=1), partial remainder=0, counter=N, go to CALC.
- Once start is accepted (after E0): busy=1, outputs unchanged, done=0.
- CALC, one step per edge (E1..EN):
  - Shift {rem,quot} left one bit; trial = rem - |divisor|, computed N+1 bits wide.
  - No borrow: rem=trial, quotient bit=1.
  - Borrow: restore rem, quotient bit=0.
  - Decrement counter; after counter reaches 0, go to FIX.
- FIX (edge E(N+1); E1 for divide-by-zero):
  - Apply signs: quotient negated if sgn=1 and operand signs differ; remainder takes the sign of the dividend.
  - Register quotient, remainder, div_zero; done=1 and busy=0 for exactly one cycle; return to IDLE.
- Latency: done high N+1 cycles after the accepting edge; divide-by-zero takes 1 cycle.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified), div_zero=1. Same result for both sgn values.
- Signed overflow (sgn=1, dividend = 100..0, divisor = all ones): quotient = 100..0, remainder = 0, div_zero=0. This falls out of the magnitude algorithm at N+1 bits; no special case.
- Start while busy=1: ignored, operands not sampled.
- Start during the done cycle: accepted (busy=0 then). Previous results stay visible until the new done.
- Inputs are not required to stay stable after the accepting edge.

Test Plan:
- N=8, unsigned 100/7, start one cycle -> done exactly 9 cycles later; q=14 (0x0E), r=2, div_zero=0; busy high cycles 1..8.
- N=8, signed 0xF9 (-7)/0x02 -> q=0xFD (-3), r=0xFF (-1). Also 7/0xFE (-2) -> q=0xFD (-3), r=0x01.
- N=8, 0x2A/0x00 with sgn=0 and sgn=1 -> done 1 cycle after accept; q=0xFF, r=0x2A, div_zero=1. Then 0x2A/0x01 -> div_zero clears, q=0x2A, r=0.
- N=8, signed 0x80/0xFF -> q=0x80, r=0x00, div_zero=0. Unsigned 0x80/0xFF -> q=0, r=0x80.
- Start 200/3; re-pulse start with 9/9 at cycle 4 -> ignored; result q=66, r=2. New start on the done cycle -> accepted, second done 9 cycles later.
- Start 255/1; assert rst at cycle 5 -> busy=0, all outputs 0, no done. Next 50/5 -> q=10, r=0 with normal latency.
